fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_controller.sv | 102 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// PC/data widths, default halt opcode and the wrapping PC increment.
package fetch_pkg;

  localparam int PC_W   = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_HALTED = ST_HALTED
  } fetch_state_t;

  localparam logic [DATA_W-1:0] DEFAULT_HALT_OPCODE = 8'hFF;

  // PC advances modulo 2^PC_W; the carry is intentionally dropped.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] cur);
    return cur + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the memory PC, holds one fetched word
// for the decoder with valid/ready handshake. Macro FETCH_HALT_OPCODE_EN makes
// a captured HALT_OPCODE stop fetch.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC    = 8'd0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] instr_out,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

`ifdef FETCH_HALT_OPCODE_EN
  localparam bit OPC_HALT_EN = 1'b1;
`else
  localparam bit OPC_HALT_EN = 1'b0;
`endif

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [DATA_W-1:0] instr_out_d;
  logic [PC_W-1:0]   instr_pc_d;
  logic              instr_valid_d;
  logic              drain;
  logic              capture;
  logic              halt_on_opc;

  assign drain       = instr_valid && instr_ready;
  assign capture     = !instr_valid || instr_ready;
  assign halt_on_opc = OPC_HALT_EN && (instruction == HALT_OPCODE);

  // Next-state: branch beats halt, halt beats capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    instr_out_d   = instr_out;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;
    case (state_q)
      S_IDLE: begin
        if (branch_valid) pc_d = branch_target;
        if (drain) instr_valid_d = 1'b0;
        if (halt) state_d = S_HALTED;
        else if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (branch_valid) begin
          pc_d          = branch_target;
          instr_valid_d = 1'b0;
          if (halt) state_d = S_HALTED;
        end else if (halt) begin
          if (drain) instr_valid_d = 1'b0;
          state_d = S_HALTED;
        end else if (capture) begin
          instr_out_d   = instruction;
          instr_pc_d    = pc;
          instr_valid_d = 1'b1;
          // A halt opcode is delivered but the PC stays on it.
          if (halt_on_opc) state_d = S_HALTED;
          else pc_d = pc_inc(pc);
        end
      end
      S_HALTED: begin
        if (drain) instr_valid_d = 1'b0;
        if (start && !halt) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register: every output is a flop, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instr_out   <= instr_out_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      halted      <= (state_d == S_HALTED);
    end
  end

endmodule
